game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4: frame_tick pulses per env_step pulse in PLAY.
REQ-002 Parameter PASS_PER_LEVEL, default 8: bars passed in PLAY to trigger a level-up.
REQ-003 Parameter MAX_LEVEL, default 10: highest level value.
REQ-004 Parameter LEVELUP_HOLD, default 60: frame_tick pulses spent in LEVEL_UP.
REQ-005 Port clkgame, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-008 Port btn_start, input, 1: debounced one-cycle start pulse.
REQ-009 Port btn_pause, input, 1: debounced one-cycle pause-toggle pulse.
REQ-010 Port collision, input, 1: high while the player overlaps a bar.
REQ-011 Port bar_passed, input, 1: one-cycle pulse when the player clears a bar.
REQ-012 Port level, output, 10: current level, 1..MAX_LEVEL (odd/even selects the obstacle pattern).
REQ-013 Port pause, output, 1: freezes the obstacle environment.
REQ-014 Port env_step, output, 1: one-cycle obstacle-advance pulse.
REQ-015 Port score, output, 10: bars passed this game, saturating.
REQ-016 Port state, output, 3: current FSM state encoding.
REQ-017 Port game_over, output, 1: high in state OVER.

Function
REQ-018 The FSM SHALL have states IDLE=0, PLAY=1, PAUSED=2, LEVEL_UP=3 and OVER=4; all other encodings SHALL return to IDLE on the next cycle.
REQ-019 All outputs SHALL be registered; a response to any input SHALL appear exactly one clkgame cycle after the sampling edge.
REQ-020 In IDLE or OVER, btn_start SHALL go to PLAY with level=1, score=0, pass count=0 and divider=0.
REQ-021 In PLAY, collision=1 SHALL go to OVER; collision has priority over every other event in the same cycle, and that cycle's bar_passed is not counted.
REQ-022 In PLAY without collision, bar_passed SHALL increment score (saturating at 999) and the pass count.
REQ-023 When the pass count reaches PASS_PER_LEVEL, the FSM SHALL go to LEVEL_UP, clear the pass count and increment level; at MAX_LEVEL, level SHALL hold.
REQ-024 In PLAY, btn_pause without collision or level-up SHALL go to PAUSED; if level-up occurs in the same cycle, the pause is dropped.
REQ-025 In PAUSED, btn_pause SHALL return to PLAY; collision and bar_passed SHALL be ignored.
REQ-026 LEVEL_UP SHALL count LEVELUP_HOLD frame_tick pulses, then go to PLAY with the divider cleared; btn_pause and btn_start SHALL be ignored.
REQ-027 btn_start SHALL be ignored in PLAY, PAUSED and LEVEL_UP; btn_pause SHALL be ignored in IDLE and OVER.
REQ-028 pause SHALL be 0 only in PLAY.
REQ-029 The divider SHALL count frame_tick pulses in PLAY only (frozen elsewhere); env_step SHALL pulse on the frame_tick where the divider equals TICK_DIV-1, and the divider then wraps to 0.
REQ-030 env_step SHALL never assert outside PLAY, nor in the cycle PLAY is exited.

Reset
REQ-031 rst=1 SHALL force state=IDLE, level=1, score=0, pause=1, env_step=0, game_over=0, and clear the divider, pass count and hold counters.
REQ-032 rst SHALL take priority over all inputs in any state, including mid-LEVEL_UP.

Structure
REQ-033 Package game_pkg SHALL hold the state encodings, the default parameter constants and the score saturation limit of 999.
REQ-034 The divider/env_step generator SHALL be a sub-module named tick_divider, with ports clkgame, rst, en, frame_tick and step.

Verification
REQ-035 Reset, then btn_start, then 8 frame_ticks -> PLAY, level=1, pause=0, env_step pulses after the 4th and 8th ticks.
REQ-036 8 bar_passed pulses in PLAY -> score=8, state=LEVEL_UP, level=2, pause=1; after 60 frame_ticks -> PLAY.
REQ-037 collision and bar_passed in the same cycle at score=5 -> OVER, score=5, game_over=1; then btn_start -> PLAY, score=0, level=1.
REQ-038 btn_pause, then 10 frame_ticks, then btn_pause -> no env_step while PAUSED; divider resumes from its frozen value.
REQ-039 Level at MAX_LEVEL=10 and 8 more passes -> LEVEL_UP with level=10; score at 999 plus bar_passed -> score=999.
REQ-040 rst in the middle of LEVEL_UP -> IDLE, level=1, score=0 on the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings, default parameters and limits for the game sequencer.
// Pure declarations; no timing or flow-control behaviour lives here.
package game_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PLAY     = 3'd1;
   localparam logic [2:0] ST_PAUSED   = 3'd2;
   localparam logic [2:0] ST_LEVEL_UP = 3'd3;
   localparam logic [2:0] ST_OVER     = 3'd4;

   localparam int DEF_TICK_DIV       = 4;
   localparam int DEF_PASS_PER_LEVEL = 8;
   localparam int DEF_MAX_LEVEL      = 10;
   localparam int DEF_LEVELUP_HOLD   = 60;

   localparam int LEVEL_W   = 10;
   localparam int SCORE_W   = 10;
   localparam int SCORE_MAX = 999;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic [SCORE_W-1:0] lim);
      return (v >= lim) ? v : v + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides frame_tick by TICK_DIV while en is high; registered step, 1-cycle latency.
// No backpressure: count freezes when en is low, rst clears count and step.
module tick_divider
   import game_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
)(
   input  logic clkgame,
   input  logic rst,
   input  logic en,
   input  logic frame_tick,
   output logic step
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          step_q, step_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(TICK_DIV - 1));

   always_comb begin
      cnt_d  = cnt_q;
      step_d = 1'b0;
      if (en && frame_tick) begin
         step_d = wrap;
         cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clkgame) begin
      if (rst) begin
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/game_sequencer.sv
// Game FSM: start/play/pause/level-up/over, score and level tracking, env_step pacing.
// All outputs registered (1-cycle latency); no backpressure, inputs are pulses sampled each cycle.
module game_sequencer
   import game_pkg::*;
#(
   parameter int TICK_DIV       = DEF_TICK_DIV,
   parameter int PASS_PER_LEVEL = DEF_PASS_PER_LEVEL,
   parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
   parameter int LEVELUP_HOLD   = DEF_LEVELUP_HOLD
)(
   input  logic               clkgame,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               btn_start,
   input  logic               btn_pause,
   input  logic               collision,
   input  logic               bar_passed,
   output logic [LEVEL_W-1:0] level,
   output logic               pause,
   output logic               env_step,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         state,
   output logic               game_over
);

   localparam int PW = $clog2(PASS_PER_LEVEL + 1);
   localparam int HW = $clog2(LEVELUP_HOLD + 1);

   logic [2:0]         state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [PW-1:0]      pass_q, pass_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               pause_q, game_over_q;
   logic               div_clr, div_en, div_rst;

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      score_d = score_q;
      pass_d  = pass_q;
      hold_d  = hold_q;
      div_clr = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (btn_start) begin
               state_d = ST_PLAY;
               level_d = LEVEL_W'(1);
               score_d = '0;
               pass_d  = '0;
               div_clr = 1'b1;
            end
         end
         ST_PLAY: begin
            if (collision) begin
               state_d = ST_OVER;
            end else begin
               if (bar_passed) begin
                  score_d = sat_inc(score_q, SCORE_W'(SCORE_MAX));
                  if (pass_q == PW'(PASS_PER_LEVEL - 1)) begin
                     pass_d  = '0;
                     hold_d  = '0;
                     state_d = ST_LEVEL_UP;
                     if (level_q < LEVEL_W'(MAX_LEVEL))
                        level_d = level_q + LEVEL_W'(1);
                  end else begin
                     pass_d = pass_q + PW'(1);
                  end
               end
               // A pause arriving with a level-up is dropped.
               if (btn_pause && state_d == ST_PLAY)
                  state_d = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (btn_pause)
               state_d = ST_PLAY;
         end
         ST_LEVEL_UP: begin
            if (frame_tick) begin
               if (hold_q == HW'(LEVELUP_HOLD - 1)) begin
                  hold_d  = '0;
                  state_d = ST_PLAY;
                  div_clr = 1'b1;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Divider only advances while PLAY is held through this edge.
   assign div_en  = (state_q == ST_PLAY) && (state_d == ST_PLAY);
   assign div_rst = rst || div_clr;

   always_ff @(posedge clkgame) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         level_q     <= LEVEL_W'(1);
         score_q     <= '0;
         pass_q      <= '0;
         hold_q      <= '0;
         pause_q     <= 1'b1;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         score_q     <= score_d;
         pass_q      <= pass_d;
         hold_q      <= hold_d;
         pause_q     <= (state_d != ST_PLAY);
         game_over_q <= (state_d == ST_OVER);
      end
   end

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
      .clkgame    (clkgame),
      .rst        (div_rst),
      .en         (div_en),
      .frame_tick (frame_tick),
      .step       (env_step)
   );

   assign level     = level_q;
   assign score     = score_q;
   assign pause     = pause_q;
   assign state     = state_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized traffic against a game-rule model.
module tb_game_sequencer;

   localparam int TICK_DIV = 4;
   localparam int PPL      = 8;
   localparam int MAXL     = 10;
   localparam int HOLD     = 60;

   localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSED = 2, S_LU = 3, S_OVER = 4;

   logic       clkgame = 1'b0;
   logic       rst = 1'b1, frame_tick = 1'b0, btn_start = 1'b0, btn_pause = 1'b0;
   logic       collision = 1'b0, bar_passed = 1'b0;
   logic [9:0] level, score;
   logic       pause, env_step, game_over;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   int m_state, m_level, m_score, m_pass, m_ticks, m_hold;
   bit m_step;

   always #5 clkgame = ~clkgame;

   game_sequencer #(
      .TICK_DIV(TICK_DIV), .PASS_PER_LEVEL(PPL), .MAX_LEVEL(MAXL), .LEVELUP_HOLD(HOLD)
   ) dut (
      .clkgame(clkgame), .rst(rst), .frame_tick(frame_tick), .btn_start(btn_start),
      .btn_pause(btn_pause), .collision(collision), .bar_passed(bar_passed),
      .level(level), .pause(pause), .env_step(env_step), .score(score),
      .state(state), .game_over(game_over)
   );

   // Game rules as a player would describe them, applied once per clock edge.
   task automatic model_step(input bit r, input bit ft, input bit st, input bit ps,
                             input bit co, input bit bp);
      m_step = 1'b0;
      if (r) begin
         m_state = S_IDLE; m_level = 1; m_score = 0; m_pass = 0; m_ticks = 0; m_hold = 0;
      end else if (m_state == S_IDLE || m_state == S_OVER) begin
         if (st) begin
            m_state = S_PLAY; m_level = 1; m_score = 0; m_pass = 0; m_ticks = 0;
         end
      end else if (m_state == S_PLAY) begin
         if (co) begin
            m_state = S_OVER;
         end else begin
            if (bp) begin
               if (m_score < 999) m_score = m_score + 1;
               m_pass = m_pass + 1;
            end
            if (m_pass == PPL) begin
               m_pass = 0; m_hold = 0; m_state = S_LU;
               if (m_level < MAXL) m_level = m_level + 1;
            end else if (ps) begin
               m_state = S_PAUSED;
            end else if (ft) begin
               m_ticks = m_ticks + 1;
               if (m_ticks == TICK_DIV) begin
                  m_ticks = 0; m_step = 1'b1;
               end
            end
         end
      end else if (m_state == S_PAUSED) begin
         if (ps) m_state = S_PLAY;
      end else if (m_state == S_LU) begin
         if (ft) begin
            m_hold = m_hold + 1;
            if (m_hold == HOLD) begin
               m_state = S_PLAY; m_ticks = 0;
            end
         end
      end else begin
         m_state = S_IDLE;
      end
   endtask

   task automatic drive(input bit r, input bit ft, input bit st, input bit ps,
                        input bit co, input bit bp);
      rst = r; frame_tick = ft; btn_start = st; btn_pause = ps; collision = co; bar_passed = bp;
      @(posedge clkgame);
      model_step(r, ft, st, ps, co, bp);
      #1;
      rst = 1'b0; frame_tick = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
      collision = 1'b0; bar_passed = 1'b0;
   endtask

   task automatic do_bar();
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < HOLD && m_state == S_LU; i++) drive(0, 1, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 1);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
      checks++; if (level !== 10'd1) begin errors++; $display("FAIL reset_level: got %0d exp 1", level); end
      checks++; if (score !== 10'd0) begin errors++; $display("FAIL reset_score: got %0d exp 0", score); end
      checks++; if (pause !== 1'b1) begin errors++; $display("FAIL reset_pause: got %0b exp 1", pause); end
      checks++; if (env_step !== 1'b0) begin errors++; $display("FAIL reset_env_step: got %0b exp 0", env_step); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0b exp 0", game_over); end
      drive(0, 0, 0, 1, 0, 0);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_pause_ignored: got %0d exp 0", state); end
   endtask

   task automatic test_start();
      bit exp_step;
      drive(0, 0, 1, 0, 0, 0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL start_state: got %0d exp 1", state); end
      checks++; if (level !== 10'd1) begin errors++; $display("FAIL start_level: got %0d exp 1", level); end
      checks++; if (pause !== 1'b0) begin errors++; $display("FAIL start_pause: got %0b exp 0", pause); end
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 0, 0, 0, 0);
         exp_step = (i == 3 || i == 7);
         checks++;
         if (env_step !== exp_step) begin
            errors++; $display("FAIL start_step tick %0d: got %0b exp %0b", i + 1, env_step, exp_step);
         end
         drive(0, 0, 0, 0, 0, 0);
         checks++;
         if (env_step !== 1'b0) begin errors++; $display("FAIL start_step_gap %0d: got %0b exp 0", i + 1, env_step); end
      end
   endtask

   task automatic test_levelup();
      drive(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 1, 0, 1);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL lu_state: got %0d exp 3", state); end
      checks++; if (score !== 10'd8) begin errors++; $display("FAIL lu_score: got %0d exp 8", score); end
      checks++; if (level !== 10'd2) begin errors++; $display("FAIL lu_level: got %0d exp 2", level); end
      checks++; if (pause !== 1'b1) begin errors++; $display("FAIL lu_pause: got %0b exp 1", pause); end
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL lu_buttons_ignored: got %0d exp 3", state); end
      for (int i = 0; i < HOLD - 1; i++) begin
         drive(0, 1, 0, 0, 0, 0);
         checks++;
         if (env_step !== 1'b0) begin errors++; $display("FAIL lu_no_step: got %0b exp 0", env_step); end
      end
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL lu_hold_early: got %0d exp 3", state); end
      drive(0, 1, 0, 0, 0, 0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL lu_hold_done: got %0d exp 1", state); end
      checks++; if (pause !== 1'b0) begin errors++; $display("FAIL lu_resume_pause: got %0b exp 0", pause); end
      for (int i = 0; i < TICK_DIV; i++) begin
         drive(0, 1, 0, 0, 0, 0);
         checks++;
         if (env_step !== (i == TICK_DIV - 1)) begin
            errors++; $display("FAIL lu_div_cleared tick %0d: got %0b exp %0b", i + 1, env_step, i == TICK_DIV - 1);
         end
      end
   endtask

   task automatic test_collision();
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1);
      checks++; if (score !== 10'd5) begin errors++; $display("FAIL col_pre_score: got %0d exp 5", score); end
      drive(0, 1, 0, 1, 1, 1);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL col_state: got %0d exp 4", state); end
      checks++; if (score !== 10'd5) begin errors++; $display("FAIL col_score: got %0d exp 5", score); end
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL col_game_over: got %0b exp 1", game_over); end
      checks++; if (env_step !== 1'b0) begin errors++; $display("FAIL col_env_step: got %0b exp 0", env_step); end
      drive(0, 0, 0, 1, 0, 0);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL over_pause_ignored: got %0d exp 4", state); end
      drive(0, 0, 1, 0, 0, 0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL restart_state: got %0d exp 1", state); end
      checks++; if (score !== 10'd0) begin errors++; $display("FAIL restart_score: got %0d exp 0", score); end
      checks++; if (level !== 10'd1) begin errors++; $display("FAIL restart_level: got %0d exp 1", level); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL restart_game_over: got %0b exp 0", game_over); end
   endtask

   task automatic test_pause();
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_state: got %0d exp 2", state); end
      checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_out: got %0b exp 1", pause); end
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 0, 0, 0, 0);
         checks++;
         if (env_step !== 1'b0) begin errors++; $display("FAIL paused_step %0d: got %0b exp 0", i, env_step); end
      end
      drive(0, 0, 1, 0, 1, 1);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL paused_ignore_state: got %0d exp 2", state); end
      checks++; if (score !== 10'd0) begin errors++; $display("FAIL paused_ignore_score: got %0d exp 0", score); end
      drive(0, 0, 0, 1, 0, 0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL unpause_state: got %0d exp 1", state); end
      drive(0, 1, 0, 0, 0, 0);
      checks++; if (env_step !== 1'b0) begin errors++; $display("FAIL resume_tick3: got %0b exp 0", env_step); end
      drive(0, 1, 0, 0, 0, 0);
      checks++; if (env_step !== 1'b1) begin errors++; $display("FAIL resume_tick4: got %0b exp 1", env_step); end
   endtask

   task automatic test_rst_levelup();
      for (int i = 0; i < PPL; i++) drive(0, 0, 0, 0, 0, 1);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL rlu_enter: got %0d exp 3", state); end
      for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL rlu_state: got %0d exp 0", state); end
      checks++; if (level !== 10'd1) begin errors++; $display("FAIL rlu_level: got %0d exp 1", level); end
      checks++; if (score !== 10'd0) begin errors++; $display("FAIL rlu_score: got %0d exp 0", score); end
      checks++; if (pause !== 1'b1) begin errors++; $display("FAIL rlu_pause: got %0b exp 1", pause); end
   endtask

   task automatic test_max_level();
      drive(0, 0, 1, 0, 0, 0);
      for (int n = 0; n < 200 && m_level < MAXL; n++) do_bar();
      checks++; if (level !== 10'd10) begin errors++; $display("FAIL max_reach: got %0d exp 10", level); end
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL max_reach_state: got %0d exp 1", state); end
      for (int i = 0; i < PPL; i++) drive(0, 0, 0, 0, 0, 1);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL max_lu_state: got %0d exp 3", state); end
      checks++; if (level !== 10'd10) begin errors++; $display("FAIL max_lu_level: got %0d exp 10", level); end
      for (int i = 0; i < HOLD; i++) drive(0, 1, 0, 0, 0, 0);
      for (int n = 0; n < 1100 && m_score < 999; n++) do_bar();
      checks++; if (score !== 10'd999) begin errors++; $display("FAIL score_reach: got %0d exp 999", score); end
      do_bar();
      checks++; if (score !== 10'd999) begin errors++; $display("FAIL score_sat: got %0d exp 999", score); end
      checks++; if (state !== 3'(m_state)) begin errors++; $display("FAIL max_state_model: got %0d exp %0d", state, m_state); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
         checks++;
         if (state !== 3'(m_state)) begin errors++; $display("FAIL rand_state c%0d: got %0d exp %0d", c, state, m_state); end
         checks++;
         if (level !== 10'(m_level)) begin errors++; $display("FAIL rand_level c%0d: got %0d exp %0d", c, level, m_level); end
         checks++;
         if (score !== 10'(m_score)) begin errors++; $display("FAIL rand_score c%0d: got %0d exp %0d", c, score, m_score); end
         checks++;
         if (pause !== (m_state != S_PLAY)) begin errors++; $display("FAIL rand_pause c%0d: got %0b exp %0b", c, pause, m_state != S_PLAY); end
         checks++;
         if (env_step !== m_step) begin errors++; $display("FAIL rand_env_step c%0d: got %0b exp %0b", c, env_step, m_step); end
         checks++;
         if (game_over !== (m_state == S_OVER)) begin errors++; $display("FAIL rand_game_over c%0d: got %0b exp %0b", c, game_over, m_state == S_OVER); end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_start();
      test_levelup();
      test_collision();
      test_pause();
      test_rst_levelup();
      test_max_level();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
